// File: rtl/div_seq_n_if.sv
// Handshake and result bundle for the sequential divider.
// The master side issues operations; the slave side is the divider.
interface div_seq_n_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] T;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y_Hi;
  logic [WIDTH-1:0] Y_Low;
  logic             V;
  logic             Z;
  logic             DZ;

  modport master (
    output start, is_signed, S, T,
    input  busy, done, Y_Hi, Y_Low, V, Z, DZ
  );

  modport slave (
    input  start, is_signed, S, T,
    output busy, done, Y_Hi, Y_Low, V, Z, DZ
  );
endinterface

// File: rtl/div_seq_n.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
// Y_Low carries the quotient and Y_Hi the remainder, ready for HI/LO loading.
module div_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_seq_n_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dmag_r;
  logic             sgn_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] y_hi_r;
  logic [WIDTH-1:0] y_low_r;
  logic             v_r;
  logic             z_r;
  logic             dz_r;

  logic             accept_s;
  logic [WIDTH:0]   diff_s;
  logic             keep_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + ONE) : x;
  endfunction

  assign accept_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // Trial subtract and sign fix-up values for the current step.
  always_comb begin
    diff_s  = {rem_r, quo_r[WIDTH-1]} - {1'b0, dmag_r};
    // A set remainder MSB means the shifted value exceeds any divisor magnitude.
    keep_s  = rem_r[WIDTH-1] | ~diff_s[WIDTH];
    q_fix_s = neg_q_r ? (~quo_r + ONE) : quo_r;
    r_fix_s = neg_r_r ? (~rem_r + ONE) : rem_r;
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dmag_r  <= {WIDTH{1'b0}};
      sgn_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      y_hi_r  <= {WIDTH{1'b0}};
      y_low_r <= {WIDTH{1'b0}};
      v_r     <= 1'b0;
      z_r     <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            sgn_r   <= bus.is_signed;
            neg_q_r <= bus.is_signed & (bus.S[WIDTH-1] ^ bus.T[WIDTH-1]);
            neg_r_r <= bus.is_signed & bus.S[WIDTH-1];
            quo_r   <= magnitude(bus.S, bus.is_signed);
            dmag_r  <= magnitude(bus.T, bus.is_signed);
            rem_r   <= {WIDTH{1'b0}};
            if (bus.T == {WIDTH{1'b0}}) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              y_low_r <= {WIDTH{1'b1}};
              y_hi_r  <= bus.S;
              v_r     <= 1'b0;
              z_r     <= 1'b0;
              dz_r    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
              cnt_r   <= CW'(WIDTH);
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (keep_s) begin
            rem_r <= diff_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIX: begin
          state_r <= ST_DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          y_low_r <= q_fix_s;
          y_hi_r  <= r_fix_s;
          // Only most-negative / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
          v_r     <= sgn_r & ~neg_q_r & quo_r[WIDTH-1];
          z_r     <= (quo_r == {WIDTH{1'b0}});
          dz_r    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.Y_Hi  = y_hi_r;
  assign bus.Y_Low = y_low_r;
  assign bus.V     = v_r;
  assign bus.Z     = z_r;
  assign bus.DZ    = dz_r;
endmodule

// File: tb/tb_div_seq_n.sv
// Bench for div_seq_n: 32-bit and 8-bit instances compared each cycle
// against a cycle-count/arithmetic model, plus directed literal results.
module tb_div_seq_n;
  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        v;
    logic        z;
    logic        dz;
  } res_t;

  logic clk;
  logic rst [2];
  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;

  div_seq_n_if #(.WIDTH(32)) bus32 ();
  div_seq_n_if #(.WIDTH(8))  bus8 ();

  div_seq_n #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst[0]), .bus(bus32));
  div_seq_n #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst[1]), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Width-normalised views of both instances.
  logic        in_start [2];
  logic        in_sgn   [2];
  logic [63:0] in_s     [2];
  logic [63:0] in_t     [2];
  logic        o_busy   [2];
  logic        o_done   [2];
  res_t        o_res    [2];

  assign in_start[0] = bus32.start;
  assign in_sgn[0]   = bus32.is_signed;
  assign in_s[0]     = 64'(bus32.S);
  assign in_t[0]     = 64'(bus32.T);
  assign o_busy[0]   = bus32.busy;
  assign o_done[0]   = bus32.done;
  assign o_res[0]    = '{q: 64'(bus32.Y_Low), r: 64'(bus32.Y_Hi), v: bus32.V, z: bus32.Z, dz: bus32.DZ};
  assign in_start[1] = bus8.start;
  assign in_sgn[1]   = bus8.is_signed;
  assign in_s[1]     = 64'(bus8.S);
  assign in_t[1]     = 64'(bus8.T);
  assign o_busy[1]   = bus8.busy;
  assign o_done[1]   = bus8.done;
  assign o_res[1]    = '{q: 64'(bus8.Y_Low), r: 64'(bus8.Y_Hi), v: bus8.V, z: bus8.Z, dz: bus8.DZ};

  function automatic res_t ref_div(input int w, input logic sgn, input logic [63:0] s, input logic [63:0] t);
    res_t        o;
    logic [63:0] mask;
    longint      a;
    longint      b;
    mask = (64'd1 << w) - 64'd1;
    o = '0;
    if (t == 64'd0) begin
      o.q  = mask;
      o.r  = s;
      o.dz = 1'b1;
      return o;
    end
    if (sgn) begin
      a   = $signed(s << (64 - w)) >>> (64 - w);
      b   = $signed(t << (64 - w)) >>> (64 - w);
      o.q = 64'(a / b) & mask;
      o.r = 64'(a % b) & mask;
      o.v = (s == (64'd1 << (w - 1))) && (t == mask);
    end else begin
      o.q = s / t;
      o.r = s % t;
    end
    o.z = (o.q == 64'd0);
    return o;
  endfunction

  res_t cur_res [2];
  assign cur_res[0] = ref_div(32, in_sgn[0], in_s[0], in_t[0]);
  assign cur_res[1] = ref_div(8,  in_sgn[1], in_s[1], in_t[1]);

  // Model: 0 idle, 1 busy (counting down to the done edge), 2 done.
  int   m_st   [2];
  int   m_cnt  [2];
  logic e_busy [2];
  logic e_done [2];
  res_t e_out  [2];
  res_t pend   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_st[i]   <= 0;
        m_cnt[i]  <= 0;
        e_busy[i] <= 1'b0;
        e_done[i] <= 1'b0;
        e_out[i]  <= '0;
      end else begin
        e_done[i] <= 1'b0;
        if (m_st[i] == 1) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_st[i]   <= 2;
            e_busy[i] <= 1'b0;
            e_done[i] <= 1'b1;
            e_out[i]  <= pend[i];
          end
        end else if (in_start[i]) begin
          if (cur_res[i].dz) begin
            m_st[i]   <= 2;
            e_done[i] <= 1'b1;
            e_out[i]  <= cur_res[i];
          end else begin
            m_st[i]   <= 1;
            m_cnt[i]  <= (i == 0) ? 33 : 9;
            e_busy[i] <= 1'b1;
            pend[i]   <= cur_res[i];
          end
        end else begin
          m_st[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_busy[i] !== e_busy[i] || o_done[i] !== e_done[i] || o_res[i] !== e_out[i]) begin
          failures++;
          $display("FAIL cycle_cmp dut=%0d t=%0t (got/exp) busy=%b/%b done=%b/%b lo=%h/%h hi=%h/%h v=%b/%b z=%b/%b dz=%b/%b",
                   i, $time, o_busy[i], e_busy[i], o_done[i], e_done[i], o_res[i].q, e_out[i].q,
                   o_res[i].r, e_out[i].r, o_res[i].v, e_out[i].v, o_res[i].z, e_out[i].z, o_res[i].dz, e_out[i].dz);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic st, input logic sgn, input logic [63:0] s, input logic [63:0] t);
    if (id == 0) begin
      bus32.start = st; bus32.is_signed = sgn; bus32.S = s[31:0]; bus32.T = t[31:0];
    end else begin
      bus8.start = st; bus8.is_signed = sgn; bus8.S = s[7:0]; bus8.T = t[7:0];
    end
  endtask

  // Accept edge falls between the two negedges; operands are scrambled afterwards.
  task automatic start_op(input int id, input logic sgn, input logic [63:0] s, input logic [63:0] t);
    @(negedge clk);
    drive(id, 1'b1, sgn, s, t);
    @(negedge clk);
    drive(id, 1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic wait_done(input int id, output int off, output int bc);
    off = 0;
    bc  = 0;
    while (!o_done[id] && off < 200) begin
      if (o_busy[id]) bc++;
      @(negedge clk);
      off++;
    end
    chk("done_seen", 64'(off < 200), 64'd1);
  endtask

  task automatic count_dones(input int id, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (o_done[id]) cnt++;
    end
  endtask

  task automatic op_lit(input int id, input logic sgn, input logic [63:0] s, input logic [63:0] t,
                        input logic [63:0] elo, input logic [63:0] ehi, input logic ev, input logic ez,
                        input logic edz, input int eoff);
    int off;
    int bc;
    start_op(id, sgn, s, t);
    wait_done(id, off, bc);
    chk("latency", 64'(off), 64'(eoff));
    chk("busy_cycles", 64'(bc), 64'(eoff));
    chk("y_low", o_res[id].q, elo);
    chk("y_hi", o_res[id].r, ehi);
    chk("flags_vzdz", {61'd0, o_res[id].v, o_res[id].z, o_res[id].dz}, {61'd0, ev, ez, edz});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   off;
    int   bc;
    int   nd;
    logic sgn;
    logic [63:0] s;
    logic [63:0] t;

    rst[0] = 1'b1;
    rst[1] = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);

    r = ref_div(32, 1'b0, 64'd100, 64'd7);
    chk("model_u_q", r.q, 64'd14);
    chk("model_u_r", r.r, 64'd2);
    r = ref_div(32, 1'b1, 64'hFFFF_FF9C, 64'd7);
    chk("model_s_q", r.q, 64'hFFFF_FFF2);
    chk("model_s_r", r.r, 64'hFFFF_FFFE);
    r = ref_div(8, 1'b1, 64'h80, 64'hFF);
    chk("model_ovf", {r.q[62:0], r.v}, {63'h80, 1'b1});

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_state", {o_res[0].q, 2'(o_busy[0]) + 2'(o_done[0])}, 66'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    op_lit(0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 1'b0, 33);
    op_lit(0, 1'b1, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFF2, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33);
    op_lit(0, 1'b1, 64'd100, 64'hFFFF_FFF9, 64'hFFFF_FFF2, 64'd2, 1'b0, 1'b0, 1'b0, 33);
    op_lit(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 64'd0, 1'b1, 1'b0, 1'b0, 33);
    op_lit(0, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 64'h8000_0000, 1'b0, 1'b1, 1'b0, 33);
    op_lit(0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF, 64'd5, 1'b0, 1'b0, 1'b1, 0);
    op_lit(0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 33);

    // start pulsed mid-run must neither disturb the result nor queue an operation
    start_op(0, 1'b0, 64'd100, 64'd7);
    repeat (10) @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'd1, 64'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    wait_done(0, off, bc);
    chk("midrun_lo", o_res[0].q, 64'd14);
    chk("midrun_hi", o_res[0].r, 64'd2);
    count_dones(0, 40, nd);
    chk("midrun_no_extra_done", 64'(nd), 64'd0);

    // back-to-back: start held in the done cycle
    start_op(0, 1'b0, 64'd1000, 64'd10);
    wait_done(0, off, bc);
    drive(0, 1'b1, 1'b0, 64'd9, 64'd3);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    wait_done(0, off, bc);
    chk("b2b_latency", 64'(off), 64'd33);
    chk("b2b_lo", o_res[0].q, 64'd3);

    // reset during iteration 10 aborts with no done
    start_op(0, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort_outputs", {o_res[0], 1'b0, o_busy[0], o_done[0]}, '0);
    count_dones(0, 40, nd);
    chk("abort_no_done", 64'(nd), 64'd0);

    // reset and start together: reset wins
    @(negedge clk);
    rst[0] = 1'b1;
    drive(0, 1'b1, 1'b0, 64'd9, 64'd3);
    @(negedge clk);
    rst[0] = 1'b0;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    chk("rst_start_busy", 64'(o_busy[0]), 64'd0);
    count_dones(0, 40, nd);
    chk("rst_start_no_done", 64'(nd), 64'd0);

    op_lit(1, 1'b0, 64'd200, 64'd13, 64'd15, 64'd5, 1'b0, 1'b0, 1'b0, 9);
    op_lit(1, 1'b1, 64'h80, 64'hFF, 64'h80, 64'd0, 1'b1, 1'b0, 1'b0, 9);

    repeat (60) begin
      sgn = 1'($urandom_range(0, 1));
      s   = 64'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0:       t = 64'd0;
        1:       t = 64'hFF;
        2:       t = 64'd1;
        default: t = 64'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) s = 64'h80;
      start_op(1, sgn, s, t);
      wait_done(1, off, bc);
    end

    repeat (15) begin
      sgn = 1'($urandom_range(0, 1));
      s   = 64'($urandom);
      t   = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom >> $urandom_range(0, 31));
      start_op(0, sgn, s, t);
      wait_done(0, off, bc);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
